// File: rtl/midi_pkg.sv
// midi_pkg: shared MIDI constants, status-byte classifiers and transmitter FSM state type.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package midi_pkg;

  localparam int MIDI_BAUD = 31250;

  localparam logic [7:0] STATUS_MIN    = 8'h80;
  localparam logic [7:0] SYSCOMMON_MIN = 8'hF0;
  localparam logic [7:0] REALTIME_MIN  = 8'hF8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_e;

  // Channel voice/mode status, 0x80-0xEF: the bytes running status may elide.
  function automatic logic is_chan_status(input logic [7:0] b);
    return (b >= STATUS_MIN) && (b < SYSCOMMON_MIN);
  endfunction

  // System common / SysEx, 0xF0-0xF7: these cancel any running status.
  function automatic logic is_syscommon(input logic [7:0] b);
    return (b >= SYSCOMMON_MIN) && (b < REALTIME_MIN);
  endfunction

endpackage

// File: rtl/midi_tx_fifo.sv
// midi_tx_fifo: single-clock first-word-fall-through byte FIFO, DEPTH a power of two.
// Latency: a written word is visible on rd_dat_o the cycle after the write edge.
// Backpressure: wr_rdy_o low while full and until the first edge after reset release.
module midi_tx_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         wr_vld_i,
  input  logic [W-1:0] wr_dat_i,
  output logic         wr_rdy_o,
  output logic         rd_vld_o,
  output logic [W-1:0] rd_dat_o,
  input  logic         rd_pop_i
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   cnt_q;
  logic          up_q;
  logic          wr_en, rd_en;

  assign wr_rdy_o = up_q && (cnt_q != (AW+1)'(DEPTH));
  assign rd_vld_o = (cnt_q != '0);
  assign rd_dat_o = mem_q[rd_ptr_q];
  assign wr_en    = wr_vld_i && wr_rdy_o;
  assign rd_en    = rd_pop_i && rd_vld_o;

  // Storage array: data only, occupancy is tracked separately so no reset needed.
  always_ff @(posedge clk_i) begin
    if (wr_en) mem_q[wr_ptr_q] <= wr_dat_i;
  end

  // Pointers and occupancy; simultaneous write and read leaves the count unchanged.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      up_q     <= 1'b0;
    end else begin
      up_q <= 1'b1;
      if (wr_en) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (rd_en) rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({wr_en, rd_en})
        2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
        2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/midi_tx.sv
// midi_tx: 8N1 MIDI transmitter (CLK_HZ/BAUD cycles per bit) fed by a FIFO; MIDI_RUNNING_STATUS_EN adds running-status compression.
// Latency: MIDI_OUT falls 2 cycles after a byte is accepted by an idle transmitter; frames run back-to-back.
// Backpressure: tx_ready drops only while the FIFO holds FIFO_DEPTH bytes (and during/just after reset).
module midi_tx
  import midi_pkg::*;
#(
  parameter int CLK_HZ     = 50000000,
  parameter int BAUD       = MIDI_BAUD,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       CLK_50MHZ,
  input  logic       RST_N,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       MIDI_OUT,
  output logic       tx_busy
);
  localparam int BIT_CYC = CLK_HZ / BAUD;
  localparam int CNT_W   = (BIT_CYC > 1) ? $clog2(BIT_CYC) : 1;
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(BIT_CYC - 1);

  logic       fifo_vld;
  logic [7:0] fifo_dat;
  logic       fifo_pop;
  logic       drop_head;
  logic       can_load;
  logic       load;

  tx_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       sh_q, sh_d;
  logic             line_q, line_d;

  midi_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (8)
  ) u_fifo (
    .clk_i    (CLK_50MHZ),
    .rst_ni   (RST_N),
    .wr_vld_i (tx_valid),
    .wr_dat_i (tx_data),
    .wr_rdy_o (tx_ready),
    .rd_vld_o (fifo_vld),
    .rd_dat_o (fifo_dat),
    .rd_pop_i (fifo_pop)
  );

  // A redundant status byte is popped as soon as it reaches the head, even
  // mid-frame, so it never costs line time; the cache already reflects every
  // byte ahead of it because the cache updates at load, not at transmit.
  assign can_load = fifo_vld && !drop_head;
  assign fifo_pop = load || drop_head;
  assign tx_busy  = (state_q != ST_IDLE) || fifo_vld;
  assign MIDI_OUT = line_q;

`ifdef MIDI_RUNNING_STATUS_EN
  logic [7:0] rs_q, rs_d;
  logic       rs_vld_q, rs_vld_d;

  assign drop_head = fifo_vld && rs_vld_q && is_chan_status(fifo_dat) && (fifo_dat == rs_q);

  // Running-status cache: channel status replaces it, system common clears it, others leave it.
  always_comb begin
    rs_d     = rs_q;
    rs_vld_d = rs_vld_q;
    if (load) begin
      if (is_chan_status(fifo_dat)) begin
        rs_d     = fifo_dat;
        rs_vld_d = 1'b1;
      end else if (is_syscommon(fifo_dat)) begin
        rs_vld_d = 1'b0;
      end
    end
  end

  // Running-status cache register.
  always_ff @(posedge CLK_50MHZ or negedge RST_N) begin
    if (!RST_N) begin
      rs_q     <= '0;
      rs_vld_q <= 1'b0;
    end else begin
      rs_q     <= rs_d;
      rs_vld_q <= rs_vld_d;
    end
  end
`else
  assign drop_head = 1'b0;
`endif

  // Shifter FSM next state: each state lasts one bit period of the down-counter.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    load    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (can_load) begin
          load    = 1'b1;
          sh_d    = fifo_dat;
          cnt_d   = RELOAD;
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (cnt_q == '0) begin
          cnt_d   = RELOAD;
          bit_d   = 3'd0;
          state_d = ST_DATA;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_DATA: begin
        if (cnt_q == '0) begin
          cnt_d = RELOAD;
          sh_d  = {1'b0, sh_q[7:1]};
          if (bit_q == 3'd7) state_d = ST_STOP;
          else               bit_d   = bit_q + 3'd1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_STOP: begin
        if (cnt_q == '0) begin
          if (can_load) begin
            load    = 1'b1;
            sh_d    = fifo_dat;
            cnt_d   = RELOAD;
            state_d = ST_START;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Line level follows the current state; registering it adds the one-cycle
  // lag that puts the start edge 2 cycles after the accept.
  always_comb begin
    line_d = 1'b1;
    case (state_q)
      ST_START: line_d = 1'b0;
      ST_DATA:  line_d = sh_q[0];
      default:  line_d = 1'b1;
    endcase
  end

  // State and datapath registers; reset forces the line idle high at once.
  always_ff @(posedge CLK_50MHZ or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      line_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      line_q  <= line_d;
    end
  end

endmodule

// File: tb/tb_midi_tx.sv
// tb_midi_tx: directed self-checking bench for midi_tx at 16 cycles per bit (510000/31250 truncated).
// Latency: outputs sampled 1 time unit after each rising edge; inputs driven at the same point.
// Backpressure: pushes wait (bounded) for tx_ready; drains wait (bounded) for tx_busy low.
module tb_midi_tx;

  localparam int BIT   = 16;
  localparam int FRAME = 10 * BIT;

  typedef logic [7:0] bq_t[$];

  logic       clk;
  logic       rst_n;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       midi_out;
  logic       tx_busy;

  int checks   = 0;
  int failures = 0;
  int rx_bad   = 0;
  logic [7:0] rx_q[$];

  midi_tx #(
    .CLK_HZ     (510000),
    .BAUD       (31250),
    .FIFO_DEPTH (4)
  ) dut (
    .CLK_50MHZ (clk),
    .RST_N     (rst_n),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .MIDI_OUT  (midi_out),
    .tx_busy   (tx_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic fbit(input logic [7:0] b, input int pos);
    if (pos == 0) return 1'b0;
    if (pos == 9) return 1'b1;
    return b[pos-1];
  endfunction

  // Independent line decoder: detects the start edge and samples mid-bit.
  initial begin : monitor
    logic       prev;
    logic [7:0] b;
    prev = 1'b1;
    b    = '0;
    forever begin
      tick();
      if (rst_n && prev && !midi_out) begin
        repeat (BIT/2) tick();
        for (int k = 0; k < 8; k++) begin
          repeat (BIT) tick();
          b[k] = midi_out;
        end
        repeat (BIT) tick();
        if (midi_out) rx_q.push_back(b);
        else          rx_bad++;
      end
      prev = midi_out;
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic reset_dut();
    rst_n    = 1'b0;
    tx_valid = 1'b0;
    tx_data  = '0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    rx_q.delete();
    rx_bad = 0;
  endtask

  task automatic push(input logic [7:0] b);
    int n = 0;
    while (!tx_ready && n < 2000) begin
      tick();
      n++;
    end
    if (!tx_ready) begin
      checks++;
      failures++;
      $display("FAIL push_timeout: tx_ready=%b required 1", tx_ready);
    end
    tx_valid = 1'b1;
    tx_data  = b;
    tick();
    tx_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (tx_busy && n < 4000) begin
      tick();
      n++;
    end
    checks++;
    if (tx_busy !== 1'b0) begin
      failures++;
      $display("FAIL drain_timeout: tx_busy=%b required 0", tx_busy);
    end
    repeat (2*BIT) tick();
  endtask

  task automatic test_reset();
    rst_n    = 1'b0;
    tx_valid = 1'b0;
    tx_data  = '0;
    repeat (3) tick();
    checks++;
    if (midi_out !== 1'b1) begin failures++; $display("FAIL reset_line: got %b required 1", midi_out); end
    checks++;
    if (tx_ready !== 1'b0) begin failures++; $display("FAIL reset_ready: got %b required 0", tx_ready); end
    checks++;
    if (tx_busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b required 0", tx_busy); end
    rst_n = 1'b1;
    #2;
    checks++;
    if (tx_ready !== 1'b0) begin failures++; $display("FAIL ready_before_edge: got %b required 0", tx_ready); end
    tick();
    checks++;
    if (tx_ready !== 1'b1) begin failures++; $display("FAIL ready_first_edge: got %b required 1", tx_ready); end
    checks++;
    if (midi_out !== 1'b1 || tx_busy !== 1'b0) begin
      failures++;
      $display("FAIL idle_after_reset: line=%b busy=%b required 1 0", midi_out, tx_busy);
    end
  endtask

  task automatic test_single();
    int errs = 0;
    reset_dut();
    tx_valid = 1'b1;
    tx_data  = 8'h90;
    tick();                         // accepting edge A
    tx_valid = 1'b0;
    checks++;
    if (tx_busy !== 1'b1) begin failures++; $display("FAIL single_busy: got %b required 1", tx_busy); end
    tick();                         // A+1: must still be idle high
    checks++;
    if (midi_out !== 1'b1) begin failures++; $display("FAIL single_early_start: line=%b required 1 at A+1", midi_out); end
    tick();                         // A+2: start bit begins
    for (int i = 0; i < FRAME; i++) begin
      if (midi_out !== fbit(8'h90, i / BIT)) errs++;
      tick();
    end
    checks++;
    if (errs != 0) begin failures++; $display("FAIL single_frame: %0d bad cycles required 0", errs); end
    checks++;
    if (tx_busy !== 1'b0 || midi_out !== 1'b1) begin
      failures++;
      $display("FAIL single_end: busy=%b line=%b required 0 1", tx_busy, midi_out);
    end
    checks++;
    if (rx_q.size() != 1 || rx_q[0] !== 8'h90) begin
      failures++;
      $display("FAIL single_decode: n=%0d first=%h required 1 90", rx_q.size(), (rx_q.size() > 0) ? rx_q[0] : 8'hxx);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] seq[3];
    int errs = 0;
    seq[0] = 8'h90; seq[1] = 8'h3C; seq[2] = 8'h64;
    reset_dut();
    tx_valid = 1'b1;
    tx_data  = seq[0];
    tick();
    tx_data  = seq[1];
    tick();
    tx_data  = seq[2];
    tick();                          // sample of A+2: first start bit
    tx_valid = 1'b0;
    for (int i = 0; i < 3*FRAME; i++) begin
      if (midi_out !== fbit(seq[i / FRAME], (i % FRAME) / BIT)) errs++;
      tick();
    end
    checks++;
    if (errs != 0) begin failures++; $display("FAIL b2b_frames: %0d bad cycles required 0", errs); end
    checks++;
    if (tx_busy !== 1'b0 || midi_out !== 1'b1) begin
      failures++;
      $display("FAIL b2b_end: busy=%b line=%b required 0 1", tx_busy, midi_out);
    end
    checks++;
    if (rx_q.size() != 3) begin
      failures++;
      $display("FAIL b2b_count: got %0d required 3", rx_q.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (rx_q[i] !== seq[i]) begin failures++; $display("FAIL b2b_byte%0d: got %h required %h", i, rx_q[i], seq[i]); end
      end
    end
  endtask

  task automatic test_fill();
    int acc = 0;
    int t   = 19;
    logic was_rdy;
    reset_dut();
    tx_valid = 1'b1;
    tx_data  = 8'h01;
    for (int c = 0; c < 20; c++) begin
      was_rdy = tx_ready;
      tick();
      if (was_rdy) begin
        acc++;
        tx_data = 8'(acc + 1);
      end
    end
    tx_valid = 1'b0;
    checks++;
    if (acc != 5) begin failures++; $display("FAIL fill_accepts: got %0d required 5", acc); end
    checks++;
    if (tx_ready !== 1'b0) begin failures++; $display("FAIL fill_full: tx_ready=%b required 0", tx_ready); end
    while (!tx_ready && t < 400) begin
      tick();
      t++;
    end
    checks++;
    if (t != FRAME + 1) begin failures++; $display("FAIL fill_ready_rise: at A+%0d required A+%0d", t, FRAME + 1); end
    drain();
    checks++;
    if (rx_q.size() != 5) begin
      failures++;
      $display("FAIL fill_count: got %0d required 5", rx_q.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (rx_q[i] !== 8'(i + 1)) begin failures++; $display("FAIL fill_byte%0d: got %h required %h", i, rx_q[i], 8'(i + 1)); end
      end
    end
  endtask

  task automatic test_reset_midframe();
    int errs = 0;
    reset_dut();
    tx_valid = 1'b1;
    tx_data  = 8'h00;
    tick();
    tx_data  = 8'h42;
    tick();
    tx_valid = 1'b0;
    repeat (51) tick();              // cycle 50 of the 0x00 frame
    checks++;
    if (midi_out !== 1'b0) begin failures++; $display("FAIL midframe_pre: line=%b required 0", midi_out); end
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if (midi_out !== 1'b1) begin failures++; $display("FAIL midframe_line: got %b required 1", midi_out); end
    checks++;
    if (tx_busy !== 1'b0 || tx_ready !== 1'b0) begin
      failures++;
      $display("FAIL midframe_flags: busy=%b ready=%b required 0 0", tx_busy, tx_ready);
    end
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    checks++;
    if (tx_ready !== 1'b1) begin failures++; $display("FAIL midframe_ready: got %b required 1", tx_ready); end
    for (int i = 0; i < 3*FRAME; i++) begin
      if (midi_out !== 1'b1 || tx_busy !== 1'b0) errs++;
      tick();
    end
    checks++;
    if (errs != 0) begin failures++; $display("FAIL midframe_idle: %0d non-idle cycles required 0", errs); end
    rx_q.delete();
    rx_bad = 0;
  endtask

  task automatic run_seq(input string name, input bq_t seq, input bq_t exp);
    reset_dut();
    foreach (seq[i]) push(seq[i]);
    drain();
    checks++;
    if (rx_q.size() != exp.size() || rx_bad != 0) begin
      failures++;
      $display("FAIL %s_count: got %0d frames (%0d bad) required %0d", name, rx_q.size(), rx_bad, exp.size());
    end else begin
      foreach (exp[i]) begin
        checks++;
        if (rx_q[i] !== exp[i]) begin failures++; $display("FAIL %s_byte%0d: got %h required %h", name, i, rx_q[i], exp[i]); end
      end
    end
  endtask

  task automatic test_running_status();
`ifdef MIDI_RUNNING_STATUS_EN
    run_seq("rs_plain", '{8'h90, 8'h3C, 8'h64, 8'h90, 8'h3C, 8'h00},
                        '{8'h90, 8'h3C, 8'h64, 8'h3C, 8'h00});
    run_seq("rs_rt",    '{8'h90, 8'h3C, 8'h64, 8'hF8, 8'h90, 8'h3C, 8'h00},
                        '{8'h90, 8'h3C, 8'h64, 8'hF8, 8'h3C, 8'h00});
`else
    run_seq("rs_plain", '{8'h90, 8'h3C, 8'h64, 8'h90, 8'h3C, 8'h00},
                        '{8'h90, 8'h3C, 8'h64, 8'h90, 8'h3C, 8'h00});
    run_seq("rs_rt",    '{8'h90, 8'h3C, 8'h64, 8'hF8, 8'h90, 8'h3C, 8'h00},
                        '{8'h90, 8'h3C, 8'h64, 8'hF8, 8'h90, 8'h3C, 8'h00});
`endif
    run_seq("rs_sys",   '{8'h90, 8'h3C, 8'h64, 8'hF0, 8'h90, 8'h3C, 8'h00},
                        '{8'h90, 8'h3C, 8'h64, 8'hF0, 8'h90, 8'h3C, 8'h00});
  endtask

  initial begin : main
    rst_n    = 1'b0;
    tx_valid = 1'b0;
    tx_data  = '0;
    test_reset();
    test_single();
    test_back_to_back();
    test_fill();
    test_reset_midframe();
    test_running_status();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
